// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding and the funct3 -> access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } lsu_state_e;

    // Access size in bytes; 0 marks an illegal code. Width-dependent codes
    // (LD, LWU) are filtered by the caller against the bus width.
    function automatic logic [3:0] f3_size(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU:  f3_size = 4'd1;
            F3_LH, F3_LHU:  f3_size = 4'd2;
            F3_LW, F3_LWU:  f3_size = 4'd4;
            F3_LD:          f3_size = 4'd8;
            default:        f3_size = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Core-side request/response bundle and memory-side req/ack bundle.
// lsu_req_if: master = execute stage, slave = LSU.
// lsu_bus_if: master = LSU, slave = data memory.
interface lsu_req_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface lsu_bus_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_be;
    logic                  bus_ack;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_lsu_extract.sv
// Load-result extraction: shifts the two-word capture down by the byte
// offset, keeps `size` bytes and zero/sign extends to the full width.
module mem_lsu_extract #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0]         cap_i,
    input  logic [$clog2(DATA_W/8)-1:0] off_i,
    input  logic [3:0]                  size_i,
    input  logic                        signed_i,
    output logic [DATA_W-1:0]           data_o
);
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] shifted;
    logic              msb;

    // Align, locate the top byte of the access, then fill the upper lanes.
    always_comb begin
        shifted = DATA_W'(cap_i >> {off_i, 3'b000});
        msb     = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            if (b + 1 == int'(size_i)) begin
                msb = shifted[8*b+7];
            end
        end
        for (int b = 0; b < BYTES; b++) begin
            data_o[8*b +: 8] = (b < int'(size_i)) ? shifted[8*b +: 8]
                                                  : {8{signed_i & msb}};
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between execute stage and data-memory bus.
// Decodes funct3, generates byte enables, lane-aligns store data and
// extracts load data. Optional feature macro: MISALIGN_SPLIT_EN -- when
// defined, word-crossing accesses become two bus beats; otherwise they
// are answered with rsp_err and never reach the bus.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic     clk,
    input  logic     rst,
    lsu_req_if.slave core,
    lsu_bus_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    lsu_state_e        state_q;
    logic              we_q;
    logic              signed_q;
    logic [3:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] cap0_q;
`ifdef MISALIGN_SPLIT_EN
    logic              split_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cap1_q;
`endif
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rsp_load_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic [BYTES-1:0]  bus_be_q;

    logic [3:0]        size_d;
    logic [OFF_W-1:0]  off_d;
    int                end_d;
    logic              legal_d;
    logic              cross_d;
    logic [ADDR_W-1:0] addr0_d;
    logic [BYTES-1:0]  be0_d;
    logic [DATA_W-1:0] wmask_d;
    logic [DATA_W-1:0] wdata0_d;
`ifdef MISALIGN_SPLIT_EN
    int                end_q;
    logic [BYTES-1:0]  be1_d;
    logic [DATA_W-1:0] wdata1_d;
`endif

    logic [2*DATA_W-1:0] cap_w;
    logic [DATA_W-1:0]   ext_data;

    // Request decode: size, legality, word crossing and first-beat bus fields.
    always_comb begin
        size_d  = f3_size(core.req_funct3);
        off_d   = core.req_addr[OFF_W-1:0];
        end_d   = int'(off_d) + int'(size_d);
        legal_d = (size_d != 4'd0) && (int'(size_d) <= BYTES);
        // LWU only exists on the 64-bit bus; unsigned codes are load-only.
        if (core.req_funct3 == F3_LWU && BYTES == 4) begin
            legal_d = 1'b0;
        end
        if (core.req_we && core.req_funct3[2]) begin
            legal_d = 1'b0;
        end
        cross_d = end_d > BYTES;
        addr0_d = {core.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wmask_d = '0;
        for (int b = 0; b < BYTES; b++) begin
            be0_d[b] = (b >= int'(off_d)) && (b < end_d);
            if (b < int'(size_d)) begin
                wmask_d[8*b +: 8] = 8'hFF;
            end
        end
        wdata0_d = (core.req_wdata & wmask_d) << {off_d, 3'b000};
    end

`ifdef MISALIGN_SPLIT_EN
    // Second-beat fields derived from the latched request.
    always_comb begin
        end_q = int'(off_q) + int'(size_q);
        for (int b = 0; b < BYTES; b++) begin
            be1_d[b] = b < (end_q - BYTES);
        end
        wdata1_d = wdata_q >> (8 * (BYTES - int'(off_q)));
    end

    assign cap_w = {cap1_q, cap0_q};
`else
    assign cap_w = {{DATA_W{1'b0}}, cap0_q};
`endif

    mem_lsu_extract #(
        .DATA_W (DATA_W)
    ) u_extract (
        .cap_i    (cap_w),
        .off_i    (off_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (ext_data)
    );

    // Sequencer: accept, drive one or two bus beats, then pulse the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            cap0_q      <= '0;
`ifdef MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            wdata_q     <= '0;
            cap1_q      <= '0;
`endif
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core.req_valid) begin
`ifdef MISALIGN_SPLIT_EN
                        if (!legal_d) begin
`else
                        if (!legal_d || cross_d) begin
`endif
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_load_q  <= 1'b0;
                            state_q     <= RESP;
                        end else begin
                            we_q        <= core.req_we;
                            signed_q    <= ~core.req_funct3[2];
                            size_q      <= size_d;
                            off_q       <= off_d;
`ifdef MISALIGN_SPLIT_EN
                            split_q     <= cross_d;
                            wdata_q     <= core.req_wdata & wmask_d;
`endif
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= core.req_we;
                            bus_addr_q  <= addr0_d;
                            bus_wdata_q <= wdata0_d;
                            bus_be_q    <= be0_d;
                            state_q     <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (bus.bus_ack) begin
                        cap0_q <= bus.bus_rdata;
`ifdef MISALIGN_SPLIT_EN
                        if (split_q) begin
                            bus_addr_q  <= bus_addr_q + ADDR_W'(BYTES);
                            bus_be_q    <= be1_d;
                            bus_wdata_q <= wdata1_d;
                            state_q     <= BEAT1;
                        end else
`endif
                        begin
                            bus_req_q   <= 1'b0;
                            bus_be_q    <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_load_q  <= ~we_q;
                            state_q     <= RESP;
                        end
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                BEAT1: begin
                    if (bus.bus_ack) begin
                        cap1_q      <= bus.bus_rdata;
                        bus_req_q   <= 1'b0;
                        bus_be_q    <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_load_q  <= ~we_q;
                        state_q     <= RESP;
                    end
                end
`endif
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_load_q  <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign core.req_ready = (state_q == IDLE) && !rst;
    assign core.rsp_valid = rsp_valid_q;
    assign core.rsp_err   = rsp_err_q;
    assign core.rsp_rdata = rsp_load_q ? ext_data : '0;

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_be    = bus_be_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu (32-bit bus). Follows MISALIGN_SPLIT_EN
// to know whether word-crossing accesses should split or fault.
module tb_mem_lsu;
    import lsu_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    lsu_req_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) core_if ();
    lsu_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    mem_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core_if),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic        err;
        logic        split;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [31:0] rd;
    } exp_t;

    // Reference: byte-level view of the access.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rd0, input logic [31:0] rd1);
        exp_t        e;
        int          size;
        bit          sgn;
        int          off;
        int          lane;
        logic [7:0]  mem_bytes [8];
        logic [31:0] v;
        size = 0;
        sgn  = 1'b0;
        case (f3)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: begin size = 4; sgn = 1'b1; end
            3'b100: size = we ? 0 : 1;
            3'b101: size = we ? 0 : 2;
            default: size = 0;
        endcase
        off     = int'(addr % 4);
        e       = '0;
        e.split = (size != 0) && (off + size > 4);
        e.err   = (size == 0) || (e.split && !SPLIT);
        if (e.err) e.split = 1'b0;
        e.a0 = addr - 32'(off);
        e.a1 = e.a0 + 32'd4;
        for (int k = 0; k < size; k++) begin
            lane = off + k;
            if (lane < 4) begin
                e.be0[lane] = 1'b1;
                e.wd0[8*lane +: 8] = wdata[8*k +: 8];
            end else begin
                e.be1[lane-4] = 1'b1;
                e.wd1[8*(lane-4) +: 8] = wdata[8*k +: 8];
            end
        end
        for (int i = 0; i < 4; i++) begin
            mem_bytes[i]   = rd0[8*i +: 8];
            mem_bytes[i+4] = rd1[8*i +: 8];
        end
        v = '0;
        for (int k = 0; k < size; k++) v[8*k +: 8] = mem_bytes[off+k];
        if (sgn && size > 0 && size < 4 && v[8*size-1]) begin
            for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        e.rd = (e.err || we) ? 32'h0 : v;
        return e;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Entered at a negedge inside the beat; leaves at the negedge after the ack edge.
    task automatic run_beat(input string nm, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input logic we, input logic [31:0] rd,
                            input int waits);
        for (int i = 0; i <= waits; i++) begin
            check({nm, "_req"},   64'(bus_if.bus_req), 64'd1);
            check({nm, "_addr"},  64'(bus_if.bus_addr), 64'(a));
            check({nm, "_be"},    64'(bus_if.bus_be), 64'(be));
            check({nm, "_we"},    64'(bus_if.bus_we), 64'(we));
            check({nm, "_wdata"}, 64'(bus_if.bus_wdata & lane_mask(be)), 64'(wd));
            check({nm, "_ready"}, 64'(core_if.req_ready), 64'd0);
            if (i == waits) begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_rdata = rd;
            end else begin
                bus_if.bus_ack   = 1'b0;
                bus_if.bus_rdata = $urandom;
            end
            @(negedge clk);
        end
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = $urandom;
    endtask

    // Entered at a negedge with the unit idle; leaves at a negedge, idle again.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd0,
                          input logic [31:0] rd1, input int w0, input int w1,
                          output logic [31:0] got);
        exp_t e;
        e = model(we, f3, addr, wdata, rd0, rd1);
        check("idle_ready", 64'(core_if.req_ready), 64'd1);
        check("idle_busreq", 64'(bus_if.bus_req), 64'd0);
        check("idle_be", 64'(bus_if.bus_be), 64'd0);
        core_if.req_valid  = 1'b1;
        core_if.req_we     = we;
        core_if.req_funct3 = f3;
        core_if.req_addr   = addr;
        core_if.req_wdata  = wdata;
        bus_if.bus_ack     = 1'b0;
        @(negedge clk);
        core_if.req_valid  = 1'b0;
        core_if.req_addr   = $urandom;
        core_if.req_wdata  = $urandom;
        core_if.req_funct3 = 3'($urandom);
        if (e.err) begin
            check("err_valid",  64'(core_if.rsp_valid), 64'd1);
            check("err_flag",   64'(core_if.rsp_err), 64'd1);
            check("err_rdata",  64'(core_if.rsp_rdata), 64'd0);
            check("err_busreq", 64'(bus_if.bus_req), 64'd0);
        end else begin
            run_beat("b0", e.a0, e.be0, e.wd0, we, rd0, w0);
            if (e.split) run_beat("b1", e.a1, e.be1, e.wd1, we, rd1, w1);
            check("rsp_valid",  64'(core_if.rsp_valid), 64'd1);
            check("rsp_err",    64'(core_if.rsp_err), 64'd0);
            check("rsp_rdata",  64'(core_if.rsp_rdata), 64'(e.rd));
            check("rsp_busreq", 64'(bus_if.bus_req), 64'd0);
        end
        check("rsp_ready", 64'(core_if.req_ready), 64'd0);
        got = core_if.rsp_rdata;
        @(negedge clk);
        check("rsp_pulse", 64'(core_if.rsp_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected run completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        rst                = 1'b1;
        core_if.req_valid  = 1'b0;
        core_if.req_we     = 1'b0;
        core_if.req_funct3 = 3'b000;
        core_if.req_addr   = '0;
        core_if.req_wdata  = '0;
        bus_if.bus_ack     = 1'b0;
        bus_if.bus_rdata   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(core_if.req_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_ready_rel", 64'(core_if.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(core_if.rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(core_if.rsp_rdata), 64'd0);
        check("rst_rsp_err",   64'(core_if.rsp_err), 64'd0);
        check("rst_bus_req",   64'(bus_if.bus_req), 64'd0);
        check("rst_bus_we",    64'(bus_if.bus_we), 64'd0);
        check("rst_bus_addr",  64'(bus_if.bus_addr), 64'd0);
        check("rst_bus_wdata", 64'(bus_if.bus_wdata), 64'd0);
        check("rst_bus_be",    64'(bus_if.bus_be), 64'd0);
        @(negedge clk);

        do_txn(1'b0, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, got);
        check("lw_100", 64'(got), 64'hDEADBEEF);
        do_txn(1'b0, F3_LB, 32'h103, 32'h0, 32'h80FFFFFF, 32'h0, 0, 0, got);
        check("lb_103", 64'(got), 64'hFFFFFF80);
        do_txn(1'b0, F3_LBU, 32'h103, 32'h0, 32'h80FFFFFF, 32'h0, 1, 0, got);
        check("lbu_103", 64'(got), 64'h00000080);
        do_txn(1'b1, F3_LH, 32'h102, 32'h1234ABCD, 32'h5A5A5A5A, 32'h0, 0, 0, got);
        check("sh_102", 64'(got), 64'h0);
        do_txn(1'b0, F3_LW, 32'h1FE, 32'h0, 32'h11223344, 32'h55667788, 0, 0, got);
        check("lw_1fe", 64'(got), SPLIT ? 64'h77881122 : 64'h0);
        do_txn(1'b0, F3_LD, 32'h100, 32'h0, 32'hFFFFFFFF, 32'h0, 0, 0, got);
        check("ld_on_32", 64'(got), 64'h0);
        do_txn(1'b1, F3_LW, 32'hFFFFFFFD, 32'hCAFEF00D, 32'h0, 32'h0, 1, 2, got);
        check("sw_wrap", 64'(got), 64'h0);

        // Reset while a beat is waiting for ack.
        core_if.req_valid  = 1'b1;
        core_if.req_we     = 1'b1;
        core_if.req_funct3 = F3_LW;
        core_if.req_addr   = 32'h40;
        core_if.req_wdata  = 32'h01020304;
        @(negedge clk);
        core_if.req_valid = 1'b0;
        check("rb_busreq_on", 64'(bus_if.bus_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rb_busreq_off", 64'(bus_if.bus_req), 64'd0);
        check("rb_be_off", 64'(bus_if.bus_be), 64'd0);
        check("rb_ready_in_rst", 64'(core_if.req_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rb_ready", 64'(core_if.req_ready), 64'd1);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        check("rb_late_ack", 64'(core_if.rsp_valid), 64'd0);
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        check("rb_late_ack2", 64'(core_if.rsp_valid), 64'd0);

        for (int n = 0; n < 400; n++) begin
            we   = 1'($urandom);
            f3   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_rdata = $urandom;
                @(negedge clk);
                check("idle_ack_ignored", 64'(core_if.rsp_valid), 64'd0);
                bus_if.bus_ack = 1'b0;
            end
            do_txn(we, f3, addr, $urandom, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2), got);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit sitting between the execute stage and the data-memory bus. It decodes `funct3` into access size and sign extension, generates byte enables, and aligns store data and load data. With the split feature compiled in, it turns a misaligned access into two word-aligned bus beats and recombines them. It uses a request/response handshake toward the core and a req/ack handshake toward memory.

## Interface
Parameters:
- `DATA_W`, default 32: data and bus width; legal values are 32 and 64. `BYTES = DATA_W/8`.
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_valid`, in, 1: core access request.
- `req_ready`, out, 1: unit idle and able to accept.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_funct3`, in, 3: RISC-V load/store `funct3`.
- `req_addr`, in, ADDR_W: byte address.
- `req_wdata`, in, DATA_W: store data, LSB-justified.
- `rsp_valid`, out, 1: one-cycle completion pulse.
- `rsp_rdata`, out, DATA_W: extended load result; 0 for stores and errors.
- `rsp_err`, out, 1: illegal `funct3`, or misaligned access with split disabled.
- `bus_req`, out, 1: memory request, held until acked.
- `bus_we`, out, 1: memory write.
- `bus_addr`, out, ADDR_W: word-aligned address; low log2(BYTES) bits are always 0.
- `bus_wdata`, out, DATA_W: lane-positioned write data.
- `bus_be`, out, BYTES: byte enables.
- `bus_ack`, in, 1: beat complete. `bus_rdata` is valid in the same cycle.
- `bus_rdata`, in, DATA_W: read word.

## Operation
Size decode from `funct3`:
- 000 LB/SB = 1 byte, signed. 001 LH/SH = 2 bytes, signed. 010 LW/SW = 4 bytes, signed.
- 100 LBU = 1 byte, unsigned. 101 LHU = 2 bytes, unsigned.
- Only when DATA_W=64: 011 LD/SD = 8 bytes; 110 LWU = 4 bytes, unsigned.
- Everything else is illegal. Any unsigned code used with `req_we=1` is also illegal.

Other decode rules:
- Offset `off = req_addr % BYTES`. The access is misaligned when `off + size > BYTES`. Natural-alignment faults are not raised; only word-crossing counts as misaligned.

FSM states:
- IDLE: `req_ready=1`. On `req_valid`:
  - illegal, or misaligned without split: go to RESP with error, no bus access.
  - otherwise latch the request and go to BEAT0.
- BEAT0: `bus_req=1`, `bus_addr = addr & ~(BYTES-1)`, `bus_be` covers lanes `off .. min(off+size, BYTES)-1`. `bus_wdata = wdata << 8*off`. On `bus_ack`, capture the read word and go to BEAT1 if split, else RESP.
- BEAT1: `bus_addr = first address + BYTES`, which wraps modulo 2^ADDR_W. `bus_be` covers the low `off+size-BYTES` lanes. `bus_wdata = wdata >> 8*(BYTES-off)`. On `bus_ack`, go to RESP.
- RESP: `rsp_valid=1` for exactly one cycle, then IDLE.

Load result:
- Concatenate {beat1 word, beat0 word}, shift right by `8*off`, truncate to `size`, then zero- or sign-extend to DATA_W.

Write data:
- Bytes of `req_wdata` above `size` are ignored.

Bus signals outside a BEAT state:
- `bus_req=0`, `bus_be=0`. `bus_we`, `bus_addr` and `bus_wdata` hold their last values.

`bus_ack` when `bus_req=0` is ignored.

## Timing
- Reset values: state IDLE, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_wdata=0`, `bus_be=0`.
- `req_ready` is 0 while `rst=1`.
- Latency is measured from the accept edge (cycle 0), assuming ack in the first cycle of each beat:
  - aligned access: `bus_req` in cycle 1, `rsp_valid` in cycle 2.
  - split access: beats in cycles 1 and 2, `rsp_valid` in cycle 3.
  - error: `rsp_valid` in cycle 1.
- Every wait cycle on `bus_ack` adds one cycle. Bus outputs are stable while `bus_req=1` and unacked.
- Throughput: a new request is accepted no earlier than the cycle after `rsp_valid`. `req_ready=0` in every non-IDLE state.
- Reset mid-beat: the unit is IDLE with `bus_req=0` at the next edge. A late `bus_ack` is ignored and no `rsp_valid` is produced. A store already half-written by the first beat is not rolled back.

## Configuration
- `MISALIGN_SPLIT_EN` defined: word-crossing accesses are split into two beats as described above.
- Not defined: word-crossing accesses return `rsp_err=1` and `rsp_rdata=0` one cycle after accept, with no bus activity. BEAT1 and the second capture register are not built.

## Structure
- `lsu_pkg` holds:
  - the `funct3` localparams (F3_LB … F3_LWU);
  - the `lsu_state_e` enum {IDLE, BEAT0, BEAT1, RESP};
  - the function `f3_size(funct3)` returning size in bytes, with 0 meaning illegal.
- One combinational sub-module, `mem_lsu_extract`, does the shift, truncate and sign/zero extension from the 2×DATA_W capture. The FSM stays in `mem_lsu`.

## Test plan
- LW at 0x100 with `bus_rdata=0xDEADBEEF`, ack immediate: `bus_be=1111`, `rsp_rdata=0xDEADBEEF`, `rsp_valid` in cycle 2.
- LB at 0x103 with `rdata=0x80FFFFFF`: `bus_be=1000`, `rsp_rdata=0xFFFFFF80`. The same access as LBU gives `0x00000080`.
- SH at 0x102 with `wdata=0x1234ABCD`: `bus_be=1100`, `bus_wdata[31:16]=0xABCD`, `rsp_rdata=0`.
- With MISALIGN_SPLIT_EN, LW at 0x1FE and beats returning `0x11223344` then `0x55667788`:
  - bus addresses 0x1FC then 0x200;
  - `bus_be` 1100 then 0011;
  - `rsp_rdata=0x77881122`.
- Same LW at 0x1FE without the macro: `rsp_err=1` and `rsp_valid` in cycle 1, with `bus_req` never asserted. Also `funct3=011` with DATA_W=32 gives `rsp_err=1`.
- `rst` pulsed during BEAT0 with `bus_ack` held low: next cycle `bus_req=0` and `req_ready=1`. An `ack` arriving after that produces no `rsp_valid`.
